// File: rtl/lane_rx_block_decoder_if.sv
// Block/byte bus between the lane deserialisers, the block decoder and the deskew stage.
// Handshake: a block transfers on every rising edge where blk_valid & blk_ready are both high;
// blk_valid and lanes_rx_enc stay stable until that edge, and blk_ready may depend on state only.
interface lane_rx_block_decoder_if #(
   parameter int NUM_LANES = 2
);
   logic                     blk_valid;
   logic                     blk_ready;
   logic [NUM_LANES*132-1:0] lanes_rx_enc;
   logic [NUM_LANES*8-1:0]   lanes_rx;
   logic                     byte_valid;
   logic                     blk_start;
   logic                     data_os;

   modport master (
      output blk_valid, lanes_rx_enc,
      input  blk_ready, lanes_rx, byte_valid, blk_start, data_os
   );

   modport slave (
      input  blk_valid, lanes_rx_enc,
      output blk_ready, lanes_rx, byte_valid, blk_start, data_os
   );
endinterface

// File: rtl/lane_rx_block_decoder.sv
// Multi-lane receive block decoder: sync-header check, block lock and byte serialisation.
// Define DEC_STATS_EN to build the saturating sync-error counter; otherwise sync_err_cnt reads 0.
module lane_rx_block_decoder #(
   parameter int NUM_LANES       = 2,
   parameter int SYNC_ERR_THRESH = 4,
   parameter int ERR_CNT_W       = 8
) (
   input  logic                   enc_clk,
   input  logic                   rst,
   input  logic                   enable_dec,
   input  logic [1:0]             gen_speed,
   input  logic [3:0]             d_sel,
   lane_rx_block_decoder_if.slave bus,
   output logic                   sync_err,
   output logic                   block_lock,
   output logic                   enable_deskew,
   output logic [ERR_CNT_W-1:0]   sync_err_cnt,
   output logic                   dec_state_o
);
   localparam logic [1:0] GEN4     = 2'b00;
   localparam logic [1:0] GEN3     = 2'b01;
   localparam logic [1:0] GEN2     = 2'b10;
   localparam logic [1:0] GEN_RSVD = 2'b11;
   localparam int RUN_W = $clog2(SYNC_ERR_THRESH + 1);
   localparam logic [RUN_W-1:0] THRESH = RUN_W'(SYNC_ERR_THRESH);

   typedef enum logic {IDLE = 1'b0, SER = 1'b1} state_t;

   state_t                 state_q;
   logic [1:0]             mode_q;
   logic [3:0]             cnt_q;
   logic [127:0]           sh_q [NUM_LANES];
   logic [NUM_LANES*8-1:0] lanes_rx_q;
   logic                   byte_valid_q;
   logic                   blk_start_q;
   logic                   data_os_q;
   logic                   sync_err_q;
   logic                   block_lock_q;
   logic                   deskew_q;
   logic [RUN_W-1:0]       bad_run_q;
   logic [RUN_W-1:0]       good_run_q;
   logic [RUN_W-1:0]       bad_run_d;
   logic [RUN_W-1:0]       good_run_d;
   logic                   lock_d;

   logic                   last_byte;
   logic                   accept;
   logic [131:0]           lane_w [NUM_LANES];
   logic [127:0]           pay_w [NUM_LANES];
   logic [NUM_LANES-1:0]   lane_bad;
   logic [NUM_LANES-1:0]   lane_os;
   logic                   blk_bad;
   logic                   blk_os;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign lane_w[g] = bus.lanes_rx_enc[g*132 +: 132];
   end

   // Ready during the last byte lets the next block follow with no bubble.
   assign last_byte     = (state_q == SER) && (cnt_q == ((mode_q == GEN2) ? 4'd7 : 4'd15));
   assign bus.blk_ready = enable_dec && (gen_speed != GEN_RSVD) && ((state_q == IDLE) || last_byte);
   assign accept        = bus.blk_valid && bus.blk_ready;

   always_comb begin
      lane_bad = '0;
      lane_os  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         pay_w[i] = lane_w[i][127:0];
         case (gen_speed)
            GEN2: begin
               pay_w[i] = {64'd0, lane_w[i][65:2]};
               case (lane_w[i][1:0])
                  2'b01:   lane_os[i]  = 1'b0;
                  2'b10:   lane_os[i]  = 1'b1;
                  default: lane_bad[i] = 1'b1;
               endcase
            end
            GEN3: begin
               pay_w[i] = lane_w[i][131:4];
               case (lane_w[i][3:0])
                  4'b0101: lane_os[i]  = 1'b0;
                  4'b1010: lane_os[i]  = 1'b1;
                  default: lane_bad[i] = 1'b1;
               endcase
            end
            default: pay_w[i] = lane_w[i][127:0];
         endcase
      end
      if (gen_speed == GEN4) begin
         blk_bad = 1'b0;
         blk_os  = (d_sel == 4'h8);
      end else begin
         blk_bad = (|lane_bad) || ((|lane_os) && !(&lane_os));
         blk_os  = lane_os[0];
      end
   end

   // Lock bookkeeping is decided per accepted block; GEN4 has no headers so it forces lock.
   always_comb begin
      bad_run_d  = bad_run_q;
      good_run_d = good_run_q;
      lock_d     = block_lock_q;
      if (accept) begin
         if (gen_speed == GEN4) begin
            bad_run_d = '0;
            lock_d    = 1'b1;
         end else if (blk_bad) begin
            good_run_d = '0;
            if (bad_run_q < THRESH) bad_run_d = bad_run_q + RUN_W'(1);
            if (bad_run_d >= THRESH) lock_d = 1'b0;
         end else begin
            bad_run_d = '0;
            if (good_run_q < THRESH) good_run_d = good_run_q + RUN_W'(1);
            if (good_run_d >= THRESH) lock_d = 1'b1;
         end
      end
   end

   always_ff @(posedge enc_clk) begin
      if (rst) begin
         state_q      <= IDLE;
         mode_q       <= GEN4;
         cnt_q        <= '0;
         lanes_rx_q   <= '0;
         byte_valid_q <= 1'b0;
         blk_start_q  <= 1'b0;
         data_os_q    <= 1'b0;
         sync_err_q   <= 1'b0;
         block_lock_q <= 1'b0;
         deskew_q     <= 1'b0;
         bad_run_q    <= '0;
         good_run_q   <= '0;
         for (int i = 0; i < NUM_LANES; i++) sh_q[i] <= '0;
      end else begin
         bad_run_q    <= bad_run_d;
         good_run_q   <= good_run_d;
         block_lock_q <= lock_d;
         blk_start_q  <= accept;
         sync_err_q   <= accept && blk_bad;
         if (accept && !blk_bad) data_os_q <= blk_os;

         if (!enable_dec || !lock_d) deskew_q <= 1'b0;
         else if (blk_start_q && block_lock_q) deskew_q <= 1'b1;

         if (accept) begin
            state_q      <= SER;
            mode_q       <= gen_speed;
            cnt_q        <= '0;
            byte_valid_q <= 1'b1;
            for (int i = 0; i < NUM_LANES; i++) begin
               lanes_rx_q[i*8 +: 8] <= pay_w[i][7:0];
               sh_q[i]              <= pay_w[i] >> 8;
            end
         end else begin
            case (state_q)
               SER: begin
                  if (!enable_dec || last_byte) begin
                     // Abort or normal end: lanes_rx keeps the last byte shown.
                     state_q      <= IDLE;
                     byte_valid_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                     for (int i = 0; i < NUM_LANES; i++) begin
                        lanes_rx_q[i*8 +: 8] <= sh_q[i][7:0];
                        sh_q[i]              <= sh_q[i] >> 8;
                     end
                  end
               end
               default: begin
                  state_q      <= IDLE;
                  byte_valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef DEC_STATS_EN
   logic [ERR_CNT_W-1:0] err_cnt_q;

   always_ff @(posedge enc_clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if (accept && blk_bad && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
         err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
   end

   assign sync_err_cnt = err_cnt_q;
`else
   assign sync_err_cnt = '0;
`endif

   assign bus.lanes_rx   = lanes_rx_q;
   assign bus.byte_valid = byte_valid_q;
   assign bus.blk_start  = blk_start_q;
   assign bus.data_os    = data_os_q;
   assign sync_err       = sync_err_q;
   assign block_lock     = block_lock_q;
   assign enable_deskew  = deskew_q;
   assign dec_state_o    = (state_q == SER);
endmodule

// File: tb/tb_lane_rx_block_decoder.sv
// Bench for lane_rx_block_decoder: vector table, corner-case sequences and randomized blocks
// checked against a block-level reference model and an expected-byte queue.
module tb_lane_rx_block_decoder;
   localparam int NL = 2;
   localparam int THR = 4;
   localparam int CW = 8;
   localparam int WW = NL * 8;

   logic          enc_clk = 1'b0;
   logic          rst;
   logic          enable_dec;
   logic [1:0]    gen_speed;
   logic [3:0]    d_sel;
   logic          sync_err;
   logic          block_lock;
   logic          enable_deskew;
   logic [CW-1:0] sync_err_cnt;
   logic          dec_state;

   lane_rx_block_decoder_if #(.NUM_LANES(NL)) bus ();

   lane_rx_block_decoder #(
      .NUM_LANES(NL), .SYNC_ERR_THRESH(THR), .ERR_CNT_W(CW)
   ) dut (
      .enc_clk      (enc_clk),
      .rst          (rst),
      .enable_dec   (enable_dec),
      .gen_speed    (gen_speed),
      .d_sel        (d_sel),
      .bus          (bus),
      .sync_err     (sync_err),
      .block_lock   (block_lock),
      .enable_deskew(enable_deskew),
      .sync_err_cnt (sync_err_cnt),
      .dec_state_o  (dec_state)
   );

   always #5 enc_clk = ~enc_clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   // Reference model: one record per accepted block, one word per output byte.
   typedef struct packed {
      logic          os;
      logic          err;
      logic          lock;
      logic [CW-1:0] cnt;
   } stat_t;

   logic [WW-1:0] exp_q[$];
   stat_t         stat_q[$];
   int            m_bad_run = 0;
   int            m_good_run = 0;
   int            m_err_cnt = 0;
   logic          m_lock = 1'b0;
   logic          m_os = 1'b0;

   task automatic model_accept(input logic [1:0] g, input logic [3:0] ds,
                               input logic [NL*4-1:0] hdrs, input logic [NL*128-1:0] pays);
      int            nbytes;
      int            kind [NL];
      logic          bad;
      logic          os;
      logic [3:0]    h;
      logic [WW-1:0] w;
      stat_t         s;
      nbytes = (g == 2'b10) ? 8 : 16;
      bad = 1'b0;
      for (int i = 0; i < NL; i++) begin
         h = hdrs[i*4 +: 4];
         if (g == 2'b10) kind[i] = (h[1:0] == 2'b01) ? 0 : (h[1:0] == 2'b10) ? 1 : 2;
         else            kind[i] = (h == 4'h5) ? 0 : (h == 4'hA) ? 1 : 2;
      end
      if (g == 2'b00) begin
         os = (ds == 4'h8);
         m_lock = 1'b1;
         m_bad_run = 0;
      end else begin
         for (int i = 0; i < NL; i++) if (kind[i] == 2 || kind[i] != kind[0]) bad = 1'b1;
         os = (kind[0] == 1);
         if (bad) begin
            m_bad_run++;
            m_good_run = 0;
            if (m_bad_run >= THR) m_lock = 1'b0;
            if (m_err_cnt < (1 << CW) - 1) m_err_cnt++;
         end else begin
            m_bad_run = 0;
            m_good_run++;
            if (m_good_run >= THR) m_lock = 1'b1;
         end
      end
      if (!bad) m_os = os;
      s.os = m_os;
      s.err = bad;
      s.lock = m_lock;
`ifdef DEC_STATS_EN
      s.cnt = CW'(m_err_cnt);
`else
      s.cnt = '0;
`endif
      stat_q.push_back(s);
      for (int k = 0; k < nbytes; k++) begin
         for (int i = 0; i < NL; i++) w[i*8 +: 8] = pays[i*128 + 8*k +: 8];
         exp_q.push_back(w);
      end
   endtask

   function automatic logic [131:0] mk_lane(input logic [1:0] g, input logic [3:0] hdr,
                                            input logic [127:0] pay, input logic [131:0] junk);
      logic [131:0] l;
      l = junk;
      case (g)
         2'b10: begin
            l[65:2] = pay[63:0];
            l[1:0]  = hdr[1:0];
         end
         2'b01: begin
            l[131:4] = pay;
            l[3:0]   = hdr;
         end
         default: l[127:0] = pay;
      endcase
      return l;
   endfunction

   // Called at posedge+1; returns at posedge+1 right after the accepting edge (blk_start cycle).
   task automatic send_block(input logic [1:0] g, input logic [3:0] ds, input logic [NL*4-1:0] hdrs,
                             input logic [NL*128-1:0] pays, input logic [NL*132-1:0] junk);
      logic [NL*132-1:0] enc;
      int waited;
      waited = 0;
      for (int i = 0; i < NL; i++)
         enc[i*132 +: 132] = mk_lane(g, hdrs[i*4 +: 4], pays[i*128 +: 128], junk[i*132 +: 132]);
      gen_speed = g;
      d_sel = ds;
      bus.lanes_rx_enc = enc;
      bus.blk_valid = 1'b1;
      @(negedge enc_clk);
      while (!bus.blk_ready && waited < 50) begin
         waited++;
         @(negedge enc_clk);
      end
      if (!bus.blk_ready) fail_now("accept_timeout");
      else model_accept(g, ds, hdrs, pays);
      @(posedge enc_clk);
      #1;
      bus.blk_valid = 1'b0;
   endtask

   // Scoreboard / monitor, sampled on the falling edge.
   int            run_len = 0;
   int            max_run = 0;
   int            starts = 0;
   logic [WW-1:0] mon_w;
   stat_t         mon_s;

   always @(negedge enc_clk) begin
      if (!rst) begin
         if (bus.byte_valid) begin
            run_len++;
            if (exp_q.size() == 0) fail_now("unexpected_byte");
            else begin
               mon_w = exp_q.pop_front();
               chk("lane_bytes", bus.lanes_rx, mon_w);
            end
         end else begin
            run_len = 0;
         end
         if (run_len > max_run) max_run = run_len;
         if (bus.blk_start) begin
            starts++;
            chk("start_has_byte", bus.byte_valid, 1'b1);
            if (stat_q.size() == 0) fail_now("unexpected_blk_start");
            else begin
               mon_s = stat_q.pop_front();
               chk("data_os", bus.data_os, mon_s.os);
               chk("sync_err", sync_err, mon_s.err);
               chk("block_lock", block_lock, mon_s.lock);
               chk("sync_err_cnt", sync_err_cnt, mon_s.cnt);
            end
         end else begin
            chk("sync_err_idle", sync_err, 1'b0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [1:0]  g;
      logic [3:0]  ds;
      logic [3:0]  h0;
      logic [3:0]  h1;
      logic [63:0] p;
      logic        os;
      logic        err;
      logic        lock;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [63:0]       p;
      logic [NL*128-1:0] pays;
      logic [NL*4-1:0]   hdrs;
      logic [1:0]        g;
      logic [3:0]        hv;
      logic [WW-1:0]     byte5;
      logic              lock_exp [8];

      tbl[0]  = '{2'b10, 4'h0, 4'h1, 4'h1, 64'h0807060504030201, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{2'b10, 4'h0, 4'h2, 4'h2, 64'h1122334455667788, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{2'b01, 4'h0, 4'h5, 4'h5, 64'hA5A5_0F0F_1234_5678, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{2'b01, 4'h0, 4'hA, 4'hA, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{2'b01, 4'h0, 4'h5, 4'hA, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 1'b1};
      tbl[5]  = '{2'b10, 4'h0, 4'h3, 4'h1, 64'h5555_AAAA_5555_AAAA, 1'b1, 1'b1, 1'b1};
      tbl[6]  = '{2'b10, 4'h0, 4'h1, 4'h2, 64'h0F1E_2D3C_4B5A_6978, 1'b1, 1'b1, 1'b1};
      tbl[7]  = '{2'b00, 4'h8, 4'h0, 4'h0, 64'h8877_6655_4433_2211, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{2'b00, 4'h3, 4'hF, 4'h0, 64'h1357_9BDF_2468_ACE0, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{2'b01, 4'h0, 4'h0, 4'h0, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b1, 1'b1};
      tbl[10] = '{2'b10, 4'h0, 4'h0, 4'h0, 64'h0000_1111_2222_3333, 1'b0, 1'b1, 1'b1};

      rst = 1'b1;
      enable_dec = 1'b0;
      gen_speed = 2'b00;
      d_sel = 4'h0;
      bus.blk_valid = 1'b0;
      bus.lanes_rx_enc = '0;
      repeat (3) @(posedge enc_clk);
      @(negedge enc_clk);
      chk("rst_byte_valid", bus.byte_valid, 1'b0);
      chk("rst_blk_start", bus.blk_start, 1'b0);
      chk("rst_data_os", bus.data_os, 1'b0);
      chk("rst_lanes_rx", bus.lanes_rx, '0);
      chk("rst_sync_err", sync_err, 1'b0);
      chk("rst_block_lock", block_lock, 1'b0);
      chk("rst_enable_deskew", enable_deskew, 1'b0);
      chk("rst_sync_err_cnt", sync_err_cnt, '0);
      chk("rst_state", dec_state, 1'b0);
      chk("rst_blk_ready", bus.blk_ready, 1'b0);
      @(posedge enc_clk);
      #1;
      rst = 1'b0;
      enable_dec = 1'b1;
      @(posedge enc_clk);
      #1;

      for (int n = 0; n < 11; n++) begin
         p = tbl[n].p;
         pays = {{p, p ^ 64'hFF00_FF00_FF00_FF00}, {~p, p}};
         send_block(tbl[n].g, tbl[n].ds, {tbl[n].h1, tbl[n].h0}, pays, '0);
         chk($sformatf("tbl%0d_blk_start", n), bus.blk_start, 1'b1);
         chk($sformatf("tbl%0d_data_os", n), bus.data_os, tbl[n].os);
         chk($sformatf("tbl%0d_sync_err", n), sync_err, tbl[n].err);
         chk($sformatf("tbl%0d_block_lock", n), block_lock, tbl[n].lock);
         chk($sformatf("tbl%0d_byte0", n), bus.lanes_rx, {pays[128 +: 8], pays[0 +: 8]});
      end

      // Sixteen back-to-back GEN3 ordered sets.
      repeat (20) @(posedge enc_clk);
      #1;
      max_run = 0;
      starts = 0;
      for (int n = 0; n < 16; n++) begin
         pays = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         send_block(2'b01, 4'h0, {4'hA, 4'hA}, pays, '0);
      end
      chk("b2b_enable_deskew", enable_deskew, 1'b1);
      repeat (20) @(posedge enc_clk);
      #1;
      chk("b2b_run_len", max_run, 256);
      chk("b2b_starts", starts, 16);

      // Lock loss after four bad blocks, regain after four good ones.
      lock_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int n = 0; n < 8; n++) begin
         pays = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         send_block(2'b10, 4'h0, (n < 4) ? {4'h3, 4'h3} : {4'h1, 4'h1}, pays, '0);
         chk($sformatf("lock_seq%0d", n), block_lock, lock_exp[n]);
         if (n == 3) chk("lock_loss_deskew", enable_deskew, 1'b0);
      end
      @(posedge enc_clk);
      #1;
      chk("lock_regain_deskew", enable_deskew, 1'b1);

      // enable_dec dropped while byte 5 of a GEN3 block is on the bus.
      pays = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      byte5 = {pays[128 + 40 +: 8], pays[40 +: 8]};
      send_block(2'b01, 4'h0, {4'h5, 4'h5}, pays, '0);
      repeat (5) @(posedge enc_clk);
      #1;
      enable_dec = 1'b0;
      #1;
      chk("abort_ready_low", bus.blk_ready, 1'b0);
      @(posedge enc_clk);
      #1;
      chk("abort_byte_valid", bus.byte_valid, 1'b0);
      chk("abort_blk_start", bus.blk_start, 1'b0);
      chk("abort_lanes_hold", bus.lanes_rx, byte5);
      chk("abort_state", dec_state, 1'b0);
      chk("abort_deskew", enable_deskew, 1'b0);
      chk("abort_lock_kept", block_lock, m_lock);
      exp_q.delete();
      repeat (2) @(posedge enc_clk);
      #1;
      enable_dec = 1'b1;
      pays = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      send_block(2'b01, 4'h0, {4'h5, 4'h5}, pays, '0);
      chk("restart_byte0", bus.lanes_rx, {pays[128 +: 8], pays[0 +: 8]});
      repeat (20) @(posedge enc_clk);
      #1;

      // Reserved speed is never accepted.
      gen_speed = 2'b11;
      bus.blk_valid = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge enc_clk);
         chk("rsvd_ready", bus.blk_ready, 1'b0);
         chk("rsvd_byte_valid", bus.byte_valid, 1'b0);
      end
      @(posedge enc_clk);
      #1;
      bus.blk_valid = 1'b0;

      // Randomized blocks, with gen_speed disturbed mid-block.
      for (int n = 0; n < 40; n++) begin
         g = 2'($urandom_range(0, 2));
         if ($urandom_range(0, 9) < 8) begin
            hv = (g == 2'b10) ? ($urandom_range(0, 1) ? 4'h2 : 4'h1)
                              : ($urandom_range(0, 1) ? 4'hA : 4'h5);
            hdrs = {hv, hv};
         end else begin
            hdrs = 8'($urandom());
         end
         pays = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         send_block(g, 4'($urandom()), hdrs, pays,
                    {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()});
         if ($urandom_range(0, 3) == 0) gen_speed = 2'($urandom_range(0, 3));
         repeat ($urandom_range(0, 2)) begin
            @(posedge enc_clk);
            #1;
         end
      end

      for (int w = 0; w < 40 && exp_q.size() != 0; w++) @(negedge enc_clk);
      repeat (2) @(negedge enc_clk);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("stat_q_drained", stat_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
